// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Wishbone-to-HyperBus bridge.
package hyperbus_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_REQ  = 5'b00010,
    ST_XFER = 5'b00100,
    ST_ACK  = 5'b01000,
    ST_ERR  = 5'b10000
  } state_t;

  localparam int BEATS_PER_WORD = 2;
  localparam int HB_WORD_BYTES  = 2;

endpackage

// File: rtl/hyperbus_wb_bridge_timeout.sv
// Loadable down-counter; expire is high while the count sits at zero.
module hb_timeout #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 expire
);

  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire = (cnt_reg == '0);

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave splitting 32-bit accesses into two halfword beats
// on the HyperBus controller request interface.
module hyperbus_wb_bridge
  import hyperbus_pkg::*;
#(
  parameter int REG_SEL_BIT    = 28,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] hb_adr_o,
  output logic [15:0] hb_dat_o,
  input  logic [15:0] hb_dat_i,
  input  logic        hb_dready_i,
  input  logic        hb_dvalid_i,
  input  logic        hb_busy_i,
  input  logic        hb_error_i,
  output logic        hb_reg_space_o,
  output logic        hb_wrq_o,
  output logic        hb_rrq_o
);

  localparam int ADR_SHIFT = $clog2(HB_WORD_BYTES);
  localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        accept, bad_access, beat, last_beat, xfer_beat;
  logic        tmr_load, tmr_dec, tmr_expire;
  logic [31:0] hb_adr_reg, wdata_reg, rdata_reg;
  logic [15:0] rd_lo_reg;
  logic        reg_space_reg, we_reg, abort_reg, beat_reg;
  logic        adr_unused;

  // Address bits above the register-space select are don't-care.
  assign adr_unused = ^(wb_adr_i >> (REG_SEL_BIT + 1));

  assign accept     = wb_cyc_i && wb_stb_i && !hb_busy_i;
  assign bad_access = hb_error_i || (wb_adr_i[1:0] != 2'b00) ||
                      (wb_we_i && (wb_sel_i != 4'hF));
  assign beat       = we_reg ? hb_dready_i : hb_dvalid_i;
  assign last_beat  = (beat_reg == 1'(BEATS_PER_WORD - 1));
  assign xfer_beat  = (state_reg == ST_XFER) && !hb_error_i && beat;

  hb_timeout #(.CNT_WIDTH(CNT_WIDTH)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TMO_LOAD),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Controller error beats a data beat; a data beat beats timeout expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = bad_access ? ST_ERR : ST_REQ;
      ST_REQ: begin
        if (hb_error_i)      state_next = ST_ERR;
        else if (hb_busy_i)  state_next = ST_XFER;
        else if (tmr_expire) state_next = ST_ERR;
      end
      ST_XFER: begin
        if (hb_error_i)      state_next = ST_ERR;
        else if (beat)       state_next = last_beat ? ST_ACK : ST_XFER;
        else if (tmr_expire) state_next = ST_ERR;
      end
      ST_ACK:  state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    hb_wrq_o = 1'b0;
    hb_rrq_o = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_reg)
      ST_IDLE: tmr_load = accept && !bad_access;
      ST_REQ: begin
        hb_wrq_o = we_reg;
        hb_rrq_o = !we_reg;
        tmr_load = !hb_error_i && hb_busy_i;
        tmr_dec  = 1'b1;
      end
      ST_XFER: begin
        tmr_load = xfer_beat;
        tmr_dec  = 1'b1;
      end
      ST_ACK:  wb_ack_o = !abort_reg;
      ST_ERR:  wb_err_o = !abort_reg;
      default: ;
    endcase
  end

  // wb_dat_o only changes on the edge that completes a read, so it stays
  // stable through ACK and across later writes and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_adr_reg    <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      rd_lo_reg     <= '0;
      reg_space_reg <= 1'b0;
      we_reg        <= 1'b0;
      abort_reg     <= 1'b0;
      beat_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          abort_reg <= 1'b0;
          if (accept && !bad_access) begin
            hb_adr_reg    <= 32'(wb_adr_i[REG_SEL_BIT-1:ADR_SHIFT]);
            reg_space_reg <= wb_adr_i[REG_SEL_BIT];
            wdata_reg     <= wb_dat_i;
            we_reg        <= wb_we_i;
            beat_reg      <= 1'b0;
          end
        end
        ST_REQ, ST_XFER: begin
          if (!wb_cyc_i) abort_reg <= 1'b1;
          if ((state_reg == ST_REQ) && (state_next == ST_XFER)) beat_reg <= 1'b0;
          if (xfer_beat) begin
            if (!we_reg) begin
              if (last_beat) rdata_reg <= {hb_dat_i, rd_lo_reg};
              else           rd_lo_reg <= hb_dat_i;
            end
            if (!last_beat) beat_reg <= beat_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hb_adr_o       = hb_adr_reg;
  assign hb_reg_space_o = reg_space_reg;
  assign wb_dat_o       = rdata_reg;
  assign hb_dat_o       = beat_reg ? wdata_reg[31:16] : wdata_reg[15:0];

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench: table of single accesses plus hand-written timeout,
// controller-error, abort and reset sequences.
module tb_hyperbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, hb_adr_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic [15:0] hb_dat_o, hb_dat_i;
  logic        hb_dready_i, hb_dvalid_i, hb_busy_i, hb_error_i;
  logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hyperbus_wb_bridge #(
    .REG_SEL_BIT    (28),
    .TIMEOUT_CYCLES (16),
    .CNT_WIDTH      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_adr_i       (wb_adr_i),
    .wb_dat_i       (wb_dat_i),
    .wb_sel_i       (wb_sel_i),
    .wb_we_i        (wb_we_i),
    .wb_cyc_i       (wb_cyc_i),
    .wb_stb_i       (wb_stb_i),
    .wb_dat_o       (wb_dat_o),
    .wb_ack_o       (wb_ack_o),
    .wb_err_o       (wb_err_o),
    .hb_adr_o       (hb_adr_o),
    .hb_dat_o       (hb_dat_o),
    .hb_dat_i       (hb_dat_i),
    .hb_dready_i    (hb_dready_i),
    .hb_dvalid_i    (hb_dvalid_i),
    .hb_busy_i      (hb_busy_i),
    .hb_error_i     (hb_error_i),
    .hb_reg_space_o (hb_reg_space_o),
    .hb_wrq_o       (hb_wrq_o),
    .hb_rrq_o       (hb_rrq_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        hberr;
    logic [15:0] rlo;
    logic [15:0] rhi;
    logic        exp_err;
    logic [31:0] exp_adr;
    logic        exp_rs;
    logic [15:0] exp_b0;
    logic [15:0] exp_b1;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic master(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic master_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int err_at;
    // we adr dat sel hberr rlo rhi | exp_err exp_adr exp_rs exp_b0 exp_b1 exp_rdata
    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 16'h0, 16'h0,
                1'b0, 32'h0000_0080, 1'b0, 16'hBEEF, 16'hDEAD, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b0, 16'h1234, 16'h5678,
                1'b0, 32'h0000_0002, 1'b1, 16'h0, 16'h0, 32'h5678_1234};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, 1'b0, 16'h0, 16'h0,
                1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 32'h5678_1234};
    vecs[3] = '{1'b1, 32'h0000_0102, 32'hCAFE_F00D, 4'hF, 1'b0, 16'h0, 16'h0,
                1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 32'h5678_1234};
    vecs[4] = '{1'b0, 32'h0000_07FC, 32'h0, 4'hF, 1'b0, 16'hAAAA, 16'h5555,
                1'b0, 32'h0000_03FE, 1'b0, 16'h0, 16'h0, 32'h5555_AAAA};
    vecs[5] = '{1'b0, 32'h0000_0001, 32'h0, 4'hF, 1'b0, 16'h0, 16'h0,
                1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 32'h5555_AAAA};
    vecs[6] = '{1'b1, 32'h1FFF_FFFC, 32'h0123_4567, 4'hF, 1'b0, 16'h0, 16'h0,
                1'b0, 32'h07FF_FFFE, 1'b1, 16'h4567, 16'h0123, 32'h5555_AAAA};
    vecs[7] = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 16'h0, 16'h0,
                1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 32'h5555_AAAA};
    vecs[8] = '{1'b0, 32'hF000_0008, 32'h0, 4'hF, 1'b0, 16'h0001, 16'h8000,
                1'b0, 32'h0000_0004, 1'b1, 16'h0, 16'h0, 32'h8000_0001};

    rst = 1'b1;
    master_idle();
    wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    hb_dat_i = '0; hb_dready_i = 1'b0; hb_dvalid_i = 1'b0;
    hb_busy_i = 1'b0; hb_error_i = 1'b0;
    repeat (3) tick();
    chk("rst_wb_dat", wb_dat_o, 32'h0);
    chk("rst_ack_err", {wb_ack_o, wb_err_o}, 32'h0);
    chk("rst_hb_adr", hb_adr_o, 32'h0);
    chk("rst_hb_dat", hb_dat_o, 32'h0);
    chk("rst_req_rs", {hb_wrq_o, hb_rrq_o, hb_reg_space_o}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      $display("txn %0d we=%0b adr=%08h dat=%08h sel=%h", i, vecs[i].we, vecs[i].adr,
               vecs[i].dat, vecs[i].sel);
      master(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      hb_error_i = vecs[i].hberr;
      tick();
      chk($sformatf("v%0d_err", i), wb_err_o, vecs[i].exp_err);
      chk($sformatf("v%0d_req", i), hb_wrq_o | hb_rrq_o, !vecs[i].exp_err);
      if (vecs[i].exp_err) begin
        master_idle();
        hb_error_i = 1'b0;
        tick();
        chk($sformatf("v%0d_err_pulse", i), wb_err_o, 1'b0);
        chk($sformatf("v%0d_rdata_kept", i), wb_dat_o, vecs[i].exp_rdata);
      end else begin
        chk($sformatf("v%0d_wrq", i), hb_wrq_o, vecs[i].we);
        chk($sformatf("v%0d_adr", i), hb_adr_o, vecs[i].exp_adr);
        chk($sformatf("v%0d_rs", i), hb_reg_space_o, vecs[i].exp_rs);
        tick();
        tick();
        chk($sformatf("v%0d_req_hold", i), hb_wrq_o | hb_rrq_o, 1'b1);
        hb_busy_i = 1'b1;
        tick();
        chk($sformatf("v%0d_req_drop", i), hb_wrq_o | hb_rrq_o, 1'b0);
        for (int b = 0; b < 2; b++) begin
          if (vecs[i].we) begin
            chk($sformatf("v%0d_wbeat%0d", i, b), hb_dat_o,
                (b == 0) ? vecs[i].exp_b0 : vecs[i].exp_b1);
            hb_dready_i = 1'b1;
          end else begin
            hb_dvalid_i = 1'b1;
            hb_dat_i = (b == 0) ? vecs[i].rlo : vecs[i].rhi;
          end
          chk($sformatf("v%0d_early_ack%0d", i, b), wb_ack_o, 1'b0);
          tick();
          hb_dready_i = 1'b0;
          hb_dvalid_i = 1'b0;
        end
        chk($sformatf("v%0d_ack", i), wb_ack_o, 1'b1);
        chk($sformatf("v%0d_rdata", i), wb_dat_o, vecs[i].exp_rdata);
        master_idle();
        hb_busy_i = 1'b0;
        tick();
        chk($sformatf("v%0d_ack_pulse", i), wb_ack_o, 1'b0);
      end
    end

    // Controller never returns data: error exactly 16 cycles after the reload.
    $display("txn timeout read adr=00000200");
    master(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    tick();
    hb_busy_i = 1'b1;
    tick();
    chk("tmo_rrq_drop", hb_rrq_o, 1'b0);
    err_at = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (wb_err_o) begin
        err_at = n;
        break;
      end
    end
    chk("tmo_cycles", err_at, 16);
    master_idle();
    hb_busy_i = 1'b0;
    tick();
    chk("tmo_err_pulse", wb_err_o, 1'b0);

    // Controller error after the first read beat, then sticky error in IDLE.
    $display("txn ctrl error mid-xfer adr=00000040");
    master(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    hb_busy_i = 1'b1;
    tick();
    hb_dvalid_i = 1'b1;
    hb_dat_i = 16'h9999;
    tick();
    hb_dvalid_i = 1'b0;
    hb_error_i = 1'b1;
    tick();
    chk("cerr_err", wb_err_o, 1'b1);
    chk("cerr_no_ack", wb_ack_o, 1'b0);
    chk("cerr_rdata_kept", wb_dat_o, 32'h8000_0001);
    master_idle();
    hb_busy_i = 1'b0;
    tick();
    chk("cerr_err_pulse", wb_err_o, 1'b0);
    $display("txn sticky error write adr=00000080");
    master(1'b1, 32'h0000_0080, 32'h1, 4'hF);
    tick();
    chk("sticky_err", wb_err_o, 1'b1);
    chk("sticky_no_req", hb_wrq_o | hb_rrq_o, 1'b0);
    master_idle();
    hb_error_i = 1'b0;
    tick();

    // Master aborts mid-write: beats still consumed, no ack, next access waits on busy.
    $display("txn abort write adr=00000300 dat=11112222");
    master(1'b1, 32'h0000_0300, 32'h1111_2222, 4'hF);
    tick();
    hb_busy_i = 1'b1;
    tick();
    master_idle();
    chk("abort_beat0", hb_dat_o, 32'h2222);
    hb_dready_i = 1'b1;
    tick();
    chk("abort_beat1", hb_dat_o, 32'h1111);
    tick();
    hb_dready_i = 1'b0;
    chk("abort_no_ack", wb_ack_o, 1'b0);
    $display("txn read after abort adr=00000400");
    master(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_wait_busy%0d", k), hb_rrq_o | wb_ack_o, 1'b0);
    end
    hb_busy_i = 1'b0;
    tick();
    chk("abort_next_rrq", hb_rrq_o, 1'b1);
    hb_busy_i = 1'b1;
    tick();
    hb_dvalid_i = 1'b1;
    hb_dat_i = 16'hBBBB;
    tick();
    hb_dat_i = 16'hCCCC;
    tick();
    hb_dvalid_i = 1'b0;
    chk("abort_next_ack", wb_ack_o, 1'b1);
    chk("abort_next_rdata", wb_dat_o, 32'hCCCC_BBBB);
    master_idle();
    hb_busy_i = 1'b0;
    tick();

    // Reset in XFER clears every output on the next cycle.
    $display("txn reset mid-xfer adr=00000100");
    master(1'b1, 32'h0000_0100, 32'h7777_8888, 4'hF);
    tick();
    hb_busy_i = 1'b1;
    tick();
    hb_dready_i = 1'b1;
    tick();
    hb_dready_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("xrst_wb_dat", wb_dat_o, 32'h0);
    chk("xrst_ack_err", {wb_ack_o, wb_err_o}, 32'h0);
    chk("xrst_hb_adr", hb_adr_o, 32'h0);
    chk("xrst_hb_dat", hb_dat_o, 32'h0);
    chk("xrst_req_rs", {hb_wrq_o, hb_rrq_o, hb_reg_space_o}, 32'h0);
    rst = 1'b0;
    master_idle();
    hb_busy_i = 1'b0;
    tick();
    tick();
    chk("xrst_no_ack", wb_ack_o | wb_err_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
